// File: rtl/mio_arb_pkg.sv
// Shared encodings for the MIO bus arbiter: FSM states and master indices.
package mio_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic M_CPU  = 1'b0;
  localparam logic M_GAME = 1'b1;

endpackage

// File: rtl/mio_arb_lock_timer.sv
// Counts consecutive locked ownership cycles and flags the last cycle before a forced hand-over.
module mio_arb_lock_timer #(
  parameter int LOCK_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  logic [CNT_W-1:0] lock_cnt_d, lock_cnt_q;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (clr)
      lock_cnt_d = '0;
    else if (en && lock_cnt_q != CNT_MAX)
      lock_cnt_d = lock_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) lock_cnt_q <= '0;
    else      lock_cnt_q <= lock_cnt_d;
  end

  assign expired = (lock_cnt_q == CNT_LAST);

endmodule

// File: rtl/mio_bus_arbiter.sv
// Two-master round-robin arbiter for the MIO bus port (m0 = CPU, m1 = game engine).
// Define MIO_ARB_TIMEOUT_EN to bound how long a locked owner may hold the bus.
module mio_bus_arbiter
  import mio_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_ack,
  output logic          m1_ack,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          bus_mem_w,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  output logic          busy,
  output logic          arb_timeout
);

  arb_state_e    state_d, state_q;
  logic          last_d, last_q;
  logic          gnt0_d, gnt0_q, gnt1_d, gnt1_q;
  logic          ack0_d, ack0_q, ack1_d, ack1_q;
  logic          busy_d, busy_q;
  logic          timeout_d, timeout_q;
  logic [DW-1:0] rdata0_d, rdata0_q, rdata1_d, rdata1_q;
  logic          own0, own1, xfer0, xfer1, lock_exp;

  assign own0  = (state_q == ST_OWN0);
  assign own1  = (state_q == ST_OWN1);
  assign xfer0 = own0 & m0_req;
  assign xfer1 = own1 & m1_req;

`ifdef MIO_ARB_TIMEOUT_EN
  logic lock_en, state_chg;
  assign lock_en   = (own0 & m0_lock) | (own1 & m1_lock);
  assign state_chg = (state_d != state_q);

  mio_arb_lock_timer #(
    .LOCK_MAX (LOCK_MAX),
    .CNT_W    (CNT_W)
  ) u_lock_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (lock_en),
    .clr     (state_chg),
    .expired (lock_exp)
  );
  assign arb_timeout = timeout_q;
`else
  assign lock_exp    = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  // A locked owner keeps the bus; an unlocked owner yields straight to a waiting peer.
  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m0_req && m1_req) state_d = (last_q == M_GAME) ? ST_OWN0 : ST_OWN1;
        else if (m0_req)      state_d = ST_OWN0;
        else if (m1_req)      state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (m0_lock) begin
          if (lock_exp && m1_req) begin
            state_d   = ST_OWN1;
            timeout_d = 1'b1;
          end
        end else if (m1_req) state_d = ST_OWN1;
        else if (!m0_req)    state_d = ST_IDLE;
      end
      ST_OWN1: begin
        if (m1_lock) begin
          if (lock_exp && m0_req) begin
            state_d   = ST_OWN0;
            timeout_d = 1'b1;
          end
        end else if (m0_req) state_d = ST_OWN0;
        else if (!m1_req)    state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt0_d   = (state_d == ST_OWN0);
    gnt1_d   = (state_d == ST_OWN1);
    busy_d   = (state_d != ST_IDLE);
    ack0_d   = xfer0;
    ack1_d   = xfer1;
    last_d   = xfer0 ? M_CPU : (xfer1 ? M_GAME : last_q);
    rdata0_d = (xfer0 && !m0_we) ? bus_rdata : rdata0_q;
    rdata1_d = (xfer1 && !m1_we) ? bus_rdata : rdata1_q;
  end

  always_comb begin
    bus_mem_w = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    if (own0) begin
      bus_mem_w = m0_req & m0_we;
      bus_addr  = m0_addr;
      bus_wdata = m0_wdata;
    end else if (own1) begin
      bus_mem_w = m1_req & m1_we;
      bus_addr  = m1_addr;
      bus_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      last_q    <= M_GAME;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign m0_gnt   = gnt0_q;
  assign m1_gnt   = gnt1_q;
  assign m0_ack   = ack0_q;
  assign m1_ack   = ack1_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
  assign busy     = busy_q;

endmodule
